int_ratio_to_fixed_point: RTL

Multi-cycle divider that converts an integer ratio num/den into the team's decimal fixed-point pair: a signed integer part fixed_X and a 5-digit decimal fraction fixed_Y, where the fraction is the magnitude times 10^5. It is the producer for the fixed-point multiply and divide consumers. The raycaster uses it to build per-ray step and slope values from integer deltas. It uses restoring division: binary for the integer part, then one decimal digit per cycle for the fraction.

---
 rtl/fixed_point_pkg.sv | 23 ++
 rtl/decimal_digit_step.sv | 36 +++
 rtl/int_ratio_to_fixed_point.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_pkg.sv
// Shared constants and types for the integer-ratio to decimal fixed-point converter.
package fixed_point_pkg;

  localparam int FRAC_DIGITS = 5;
  localparam int FRAC_SCALE  = 100000;
  localparam int FX_X_MAX    = 511;
  localparam int FX_Y_MAX    = 99999;
  localparam int DIGIT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INT  = 2'd1,
    ST_FRAC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic neg;
    logic div_zero;
    logic sat;
  } fx_flags_t;

endpackage

// File: rtl/decimal_digit_step.sv
// One decimal long-division step: digit = floor(10*rem / den), remainder updated.
module decimal_digit_step #(
  parameter int MAG_W = 22
) (
  input  logic [MAG_W-1:0] rem,
  input  logic [MAG_W-1:0] den_mag,
  output logic [3:0]       digit,
  output logic [MAG_W-1:0] rem_next
);
  import fixed_point_pkg::*;

  localparam int T_W = MAG_W + 3;

  logic [T_W-1:0]     t;
  logic [T_W-1:0]     acc;
  logic [T_W-1:0]     mult;
  logic [DIGIT_W-1:0] dig;

  // rem < den, so 10*rem < 10*den and the greedy 8/4/2/1 search never exceeds 9
  always_comb begin
    t    = (T_W'(rem) << 3) + (T_W'(rem) << 1);
    acc  = t;
    dig  = '0;
    mult = '0;
    for (int k = 3; k >= 0; k--) begin
      mult = T_W'(den_mag) << k;
      if (acc >= mult) begin
        acc    = acc - mult;
        dig[k] = 1'b1;
      end
    end
    digit    = dig;
    rem_next = MAG_W'(acc);
  end

endmodule

// File: rtl/int_ratio_to_fixed_point.sv
// Multi-cycle num/den -> (fixed_X, fixed_Y) converter: binary integer quotient, then decimal digits.
// Build option: define ROUND_HALF_UP_EN to compute one extra digit and round the fraction half-up.
module int_ratio_to_fixed_point #(
  parameter int INT_W       = 21,
  parameter int X_W         = 10,
  parameter int Y_W         = 18,
  parameter int FRAC_DIGITS = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] num,
  input  logic [INT_W-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   fixed_X,
  output logic [Y_W-1:0]   fixed_Y,
  output logic             neg,
  output logic             div_zero,
  output logic             sat
);
  import fixed_point_pkg::*;

  localparam int M     = INT_W + 1;
  localparam int CNT_W = $clog2(INT_W);
`ifdef ROUND_HALF_UP_EN
  localparam int FRAC_CYC = FRAC_DIGITS + 1;
`else
  localparam int FRAC_CYC = FRAC_DIGITS;
`endif
  localparam logic [INT_W-1:0] Q_MAX = INT_W'(FX_X_MAX);

  state_e           state_q, state_d;
  logic [M-1:0]     den_q, rem_q;
  logic [INT_W-1:0] quo_q;
  logic [Y_W-1:0]   y_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  fx_flags_t        flags_q, flags_d;

  logic [M-1:0]     num_ext, den_ext, num_mag, den_mag;
  logic [M-1:0]     rem_sh, rem_nxt, rem_dig;
  logic [INT_W-1:0] quo_nxt;
  logic [3:0]       digit;
  logic [Y_W-1:0]   y_acc;

  logic             load_out, fin_div0, fin_sat;
  logic [INT_W-1:0] fin_q;
  logic [Y_W-1:0]   fin_y;
  logic [X_W-1:0]   x_d;
  logic [Y_W-1:0]   y_d;

  // One extra bit of magnitude so -2^(INT_W-1) is representable
  always_comb begin
    num_ext = {num[INT_W-1], num};
    den_ext = {den[INT_W-1], den};
    num_mag = num[INT_W-1] ? (~num_ext + M'(1)) : num_ext;
    den_mag = den[INT_W-1] ? (~den_ext + M'(1)) : den_ext;
  end

  // Restoring shift-subtract; quo_q holds the dividend and fills with quotient bits
  always_comb begin
    rem_sh = {rem_q[M-2:0], quo_q[INT_W-1]};
    if (rem_sh >= den_q) begin
      rem_nxt = rem_sh - den_q;
      quo_nxt = {quo_q[INT_W-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh;
      quo_nxt = {quo_q[INT_W-2:0], 1'b0};
    end
  end

  decimal_digit_step #(.MAG_W(M)) u_digit (
    .rem      (rem_q),
    .den_mag  (den_q),
    .digit    (digit),
    .rem_next (rem_dig)
  );

  always_comb y_acc = (y_q * Y_W'(10)) + Y_W'(digit);

  always_comb begin
    state_d  = state_q;
    load_out = 1'b0;
    fin_q    = quo_q;
    fin_y    = y_acc;
    fin_div0 = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (den == '0) begin
            state_d  = ST_DONE;
            load_out = 1'b1;
            fin_div0 = 1'b1;
          end else begin
            state_d = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (cnt_q == '0) begin
          if (quo_nxt > Q_MAX) begin
            state_d  = ST_DONE;
            load_out = 1'b1;
            fin_q    = quo_nxt;
          end else begin
            state_d = ST_FRAC;
          end
        end
      end
      ST_FRAC: begin
        if (cnt_q == '0) begin
          state_d  = ST_DONE;
          load_out = 1'b1;
`ifdef ROUND_HALF_UP_EN
          // Last digit is only a rounding digit; a fraction carry bumps the integer part
          fin_y = y_q + Y_W'(digit >= 4'd5);
          if (fin_y == Y_W'(FRAC_SCALE)) begin
            fin_y = '0;
            fin_q = quo_q + INT_W'(1);
          end
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fin_sat = (fin_q > Q_MAX);
    flags_d = '0;
    x_d     = '0;
    y_d     = fin_y;
    if (fin_div0) begin
      x_d              = X_W'(FX_X_MAX);
      y_d              = Y_W'(FX_Y_MAX);
      flags_d.div_zero = 1'b1;
    end else if (fin_sat) begin
      x_d         = sign_q ? (X_W'(0) - X_W'(FX_X_MAX)) : X_W'(FX_X_MAX);
      y_d         = Y_W'(FX_Y_MAX);
      flags_d.sat = 1'b1;
      flags_d.neg = sign_q;
    end else begin
      x_d         = sign_q ? (X_W'(0) - X_W'(fin_q)) : X_W'(fin_q);
      flags_d.neg = sign_q && ((fin_q != '0) || (fin_y != '0));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      fixed_X <= '0;
      fixed_Y <= '0;
      flags_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            den_q  <= den_mag;
            quo_q  <= INT_W'(num_mag);
            rem_q  <= '0;
            y_q    <= '0;
            cnt_q  <= CNT_W'(INT_W - 1);
            sign_q <= num[INT_W-1] ^ den[INT_W-1];
          end
        end
        ST_INT: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= (cnt_q == '0) ? CNT_W'(FRAC_CYC - 1) : cnt_q - CNT_W'(1);
        end
        ST_FRAC: begin
          rem_q <= rem_dig;
          y_q   <= y_acc;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
      if (load_out) begin
        fixed_X <= x_d;
        fixed_Y <= y_d;
        flags_q <= flags_d;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign neg       = flags_q.neg;
  assign div_zero  = flags_q.div_zero;
  assign sat       = flags_q.sat;

endmodule
